// File: rtl/exp4_unidade_controle_if.sv
// Control/status bundle between the sequence-game control unit and its datapath.
// The control unit holds the master side; the datapath or a bench holds the slave side.
interface exp4_unidade_controle_if;
    logic       iniciar;
    logic       jogada;
    logic       chavesIgualMemoria;
    logic       fimC;
    logic       zeraC;
    logic       contaC;
    logic       zeraR;
    logic       registraR;
    logic       pronto;
    logic       acertou;
    logic       errou;
    logic       timeout;
    logic [3:0] db_estado;

    modport master (
        input  iniciar, jogada, chavesIgualMemoria, fimC,
        output zeraC, contaC, zeraR, registraR,
        output pronto, acertou, errou, timeout, db_estado
    );

    modport slave (
        output iniciar, jogada, chavesIgualMemoria, fimC,
        input  zeraC, contaC, zeraR, registraR,
        input  pronto, acertou, errou, timeout, db_estado
    );
endinterface

// File: rtl/exp4_unidade_controle.sv
// Moore control unit for the sequence-check game: one move per address,
// edge-detected jogada, per-move timeout in ESPERA.
//
// state       | meaning
// INICIAL     | idle after reset, waiting for iniciar
// PREPARA     | clear address counter and chaves register
// ESPERA      | wait for a jogada edge, timeout counter running
// REGISTRA    | load chaves register
// COMPARA     | evaluate chaves against memory
// PROXIMO     | advance address counter
// FIM_ACERTO  | whole sequence matched
// FIM_TIMEOUT | player took too long
// FIM_ERRO    | move mismatched
module exp4_unidade_controle #(
    parameter int TIMEOUT_CYCLES = 5000,
    parameter int TW             = 13
) (
    input  logic                    clock,
    input  logic                    reset,
    exp4_unidade_controle_if.master bus
);

    typedef enum logic [3:0] {
        INICIAL     = 4'h0,
        PREPARA     = 4'h1,
        ESPERA      = 4'h2,
        REGISTRA    = 4'h3,
        COMPARA     = 4'h4,
        PROXIMO     = 4'h5,
        FIM_ACERTO  = 4'hA,
        FIM_TIMEOUT = 4'hD,
        FIM_ERRO    = 4'hE
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic            r_jog_prev;
    logic [TW-1:0]   r_tmo_cnt;
    logic            w_jog_pulse;
    logic            w_tmo_expired;

    assign w_jog_pulse   = bus.jogada & ~r_jog_prev;
    assign w_tmo_expired = (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= INICIAL;
            r_jog_prev <= 1'b0;
            r_tmo_cnt  <= '0;
        end else begin
            r_state    <= w_next;
            r_jog_prev <= bus.jogada;
            // Counts only while waiting, so each ESPERA visit starts from zero.
            if (r_state == ESPERA)
                r_tmo_cnt <= r_tmo_cnt + TW'(1);
            else
                r_tmo_cnt <= '0;
        end
    end

    always_comb begin
        w_next = INICIAL;
        case (r_state)
            INICIAL:     w_next = bus.iniciar ? PREPARA : INICIAL;
            PREPARA:     w_next = ESPERA;
            ESPERA: begin
                if (w_jog_pulse)
                    w_next = REGISTRA;
                else if (w_tmo_expired)
                    w_next = FIM_TIMEOUT;
                else
                    w_next = ESPERA;
            end
            REGISTRA:    w_next = COMPARA;
            COMPARA: begin
                if (!bus.chavesIgualMemoria)
                    w_next = FIM_ERRO;
                else if (bus.fimC)
                    w_next = FIM_ACERTO;
                else
                    w_next = PROXIMO;
            end
            PROXIMO:     w_next = ESPERA;
            FIM_ACERTO,
            FIM_TIMEOUT,
            FIM_ERRO:    w_next = bus.iniciar ? PREPARA : r_state;
            default:     w_next = INICIAL;
        endcase
    end

    always_comb begin
        bus.zeraC     = (r_state == PREPARA);
        bus.zeraR     = (r_state == PREPARA);
        bus.registraR = (r_state == REGISTRA);
        bus.contaC    = (r_state == PROXIMO);
        bus.pronto    = (r_state == FIM_ACERTO) || (r_state == FIM_ERRO) ||
                        (r_state == FIM_TIMEOUT);
        bus.acertou   = (r_state == FIM_ACERTO);
        bus.errou     = (r_state == FIM_ERRO) || (r_state == FIM_TIMEOUT);
        bus.timeout   = (r_state == FIM_TIMEOUT);
        bus.db_estado = r_state;
    end

endmodule

// File: tb/tb_exp4_unidade_controle.sv
// Directed bench for exp4_unidade_controle with a 20-cycle move timeout.
module tb_exp4_unidade_controle;

    logic clock = 1'b0;
    logic reset = 1'b1;

    exp4_unidade_controle_if bus_if ();

    exp4_unidade_controle #(
        .TIMEOUT_CYCLES (20),
        .TW             (13)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clock = ~clock;

    // {zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout}
    logic [7:0] w_outs;
    assign w_outs = {bus_if.zeraC, bus_if.contaC, bus_if.zeraR, bus_if.registraR,
                     bus_if.pronto, bus_if.acertou, bus_if.errou, bus_if.timeout};

    int n_chk  = 0;
    int n_pass = 0;
    int cnt_zera;
    int cnt_conta;
    int cnt_reg;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
            cnt_zera  += int'(bus_if.zeraC);
            cnt_conta += int'(bus_if.contaC);
            cnt_reg   += int'(bus_if.registraR);
        end
    endtask

    task automatic clr_counts();
        cnt_zera  = 0;
        cnt_conta = 0;
        cnt_reg   = 0;
    endtask

    // From ESPERA: press, register, compare; walks through PROXIMO back to ESPERA.
    task automatic move(input logic eq, input logic last, input string tag);
        bus_if.jogada             = 1'b1;
        bus_if.chavesIgualMemoria = eq;
        bus_if.fimC               = last;
        step(1);
        chk({tag, "_registra"}, 32'(bus_if.db_estado), 32'h3);
        bus_if.jogada = 1'b0;
        step(1);
        chk({tag, "_compara"}, 32'(bus_if.db_estado), 32'h4);
        step(1);
        if (eq && !last) begin
            chk({tag, "_proximo"}, 32'(bus_if.db_estado), 32'h5);
            step(1);
        end
    endtask

    task automatic start_round();
        bus_if.iniciar = 1'b1;
        step(1);
        bus_if.iniciar = 1'b0;
        step(1);
    endtask

    initial begin
        int esp_cycles;
        bus_if.iniciar            = 1'b0;
        bus_if.jogada             = 1'b0;
        bus_if.chavesIgualMemoria = 1'b0;
        bus_if.fimC               = 1'b0;
        clr_counts();

        step(2);
        chk("rst_state", 32'(bus_if.db_estado), 32'h0);
        chk("rst_outs", 32'(w_outs), 32'h00);
        reset = 1'b0;
        step(10);
        chk("idle_state", 32'(bus_if.db_estado), 32'h0);
        chk("idle_outs", 32'(w_outs), 32'h00);

        // Full correct round over 4 addresses
        bus_if.iniciar = 1'b1;
        step(1);
        chk("prep_state", 32'(bus_if.db_estado), 32'h1);
        chk("prep_outs", 32'(w_outs), 32'hA0);
        bus_if.iniciar = 1'b0;
        step(1);
        chk("espera_state", 32'(bus_if.db_estado), 32'h2);
        clr_counts();
        move(1'b1, 1'b0, "ok1");
        move(1'b1, 1'b0, "ok2");
        move(1'b1, 1'b0, "ok3");
        move(1'b1, 1'b1, "ok4");
        chk("ok_state", 32'(bus_if.db_estado), 32'hA);
        chk("ok_outs", 32'(w_outs), 32'h0C);
        chk("ok_contaC", 32'(cnt_conta), 32'd3);
        chk("ok_registraR", 32'(cnt_reg), 32'd4);
        step(5);
        chk("ok_hold", 32'(bus_if.db_estado), 32'hA);

        // Mismatch on the second move
        start_round();
        clr_counts();
        move(1'b1, 1'b0, "er1");
        move(1'b0, 1'b0, "er2");
        chk("err_state", 32'(bus_if.db_estado), 32'hE);
        chk("err_outs", 32'(w_outs), 32'h0A);
        chk("err_contaC", 32'(cnt_conta), 32'd1);
        bus_if.jogada = 1'b1;
        step(1);
        bus_if.jogada = 1'b0;
        step(1);
        chk("err_ignores_jogada", 32'(bus_if.db_estado), 32'hE);

        // Restart straight from FIM_ERRO, then let the move time out
        clr_counts();
        bus_if.iniciar = 1'b1;
        step(1);
        chk("restart_state", 32'(bus_if.db_estado), 32'h1);
        chk("restart_outs", 32'(w_outs), 32'hA0);
        bus_if.iniciar = 1'b0;
        step(1);
        chk("restart_espera", 32'(bus_if.db_estado), 32'h2);
        chk("restart_zera_once", 32'(cnt_zera), 32'd1);
        esp_cycles = 1;
        for (int i = 0; i < 100; i++) begin
            step(1);
            if (bus_if.db_estado != 4'h2) break;
            esp_cycles++;
        end
        chk("tmo_cycles", 32'(esp_cycles), 32'd20);
        chk("tmo_state", 32'(bus_if.db_estado), 32'hD);
        chk("tmo_outs", 32'(w_outs), 32'h0B);

        // Press in the last ESPERA cycle, then hold it for 50 cycles
        start_round();
        step(19);
        chk("last_cycle_espera", 32'(bus_if.db_estado), 32'h2);
        clr_counts();
        bus_if.jogada             = 1'b1;
        bus_if.chavesIgualMemoria = 1'b1;
        bus_if.fimC               = 1'b0;
        step(1);
        chk("edge_beats_tmo", 32'(bus_if.db_estado), 32'h3);
        step(49);
        chk("held_single_reg", 32'(cnt_reg), 32'd1);
        chk("held_then_tmo", 32'(bus_if.db_estado), 32'hD);
        bus_if.jogada = 1'b0;

        // Asynchronous reset in the middle of COMPARA
        start_round();
        bus_if.jogada = 1'b1;
        step(1);
        bus_if.jogada = 1'b0;
        step(1);
        chk("mid_compara", 32'(bus_if.db_estado), 32'h4);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_state", 32'(bus_if.db_estado), 32'h0);
        chk("async_rst_outs", 32'(w_outs), 32'h00);
        step(1);
        reset = 1'b0;
        step(1);
        chk("post_rst_state", 32'(bus_if.db_estado), 32'h0);
        chk("post_rst_outs", 32'(w_outs), 32'h00);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/exp4_unidade_controle.md
Name: exp4_unidade_controle

Overview:
Moore control unit for the round-based "sequence check" game datapath: counter over memory addresses, chaves register, and memory comparator. It waits for iniciar, clears the datapath, then takes one player move per address through an edge-detected jogada input. Each move is registered and compared against memory, and the counter advances until the whole sequence matches, one move mismatches, or the player takes too long. It sits beside the datapath in the top level, and db_estado drives the state hex display.

Parameters:
TIMEOUT_CYCLES  5000  clock cycles allowed in ESPERA before timeout (benches use 20)
TW  13  width of internal timeout counter; must satisfy 2^TW > TIMEOUT_CYCLES

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; forces INICIAL
iniciar  in  1  start or restart request, level sampled each cycle
jogada  in  1  player move button, level; rising edge detected internally
chavesIgualMemoria  in  1  datapath compare result (registered chaves == memory[count])
fimC  in  1  datapath counter at last address
zeraC  out  1  clear address counter
contaC  out  1  increment address counter
zeraR  out  1  clear chaves register
registraR  out  1  load chaves register
pronto  out  1  round finished (any end state)
acertou  out  1  round ended with full match
errou  out  1  round ended with mismatch or timeout
timeout  out  1  round ended by timeout
db_estado  out  4  current state code

Behaviour:
- All outputs are decoded from the state register only (Moore); no combinational input-to-output paths.
- Edge detector: jog_prev flop, reset value 0. jog_pulse = jogada & ~jog_prev. A held button yields exactly one pulse.
- State codes:
  - INICIAL=0
  - PREPARA=1
  - ESPERA=2
  - REGISTRA=3
  - COMPARA=4
  - PROXIMO=5
  - FIM_ACERTO=A
  - FIM_TIMEOUT=D
  - FIM_ERRO=E
  - Unused codes go to INICIAL on the next clock.
- Transitions:
  - INICIAL: iniciar -> PREPARA; else stay.
  - PREPARA: -> ESPERA unconditionally. zeraC=1 and zeraR=1 for exactly this one cycle.
  - ESPERA: jog_pulse -> REGISTRA. Else if tmo_cnt == TIMEOUT_CYCLES-1 -> FIM_TIMEOUT. Else stay.
  - Simultaneous jog_pulse and timeout expiry: jog_pulse wins.
  - REGISTRA: registraR=1 for one cycle -> COMPARA.
  - COMPARA: !chavesIgualMemoria -> FIM_ERRO. Else if fimC -> FIM_ACERTO. Else -> PROXIMO.
  - PROXIMO: contaC=1 for one cycle -> ESPERA.
  - FIM_*: hold until iniciar, then -> PREPARA (restart without passing INICIAL). jogada is ignored in end states.
- Output decode:
  - pronto=1 in FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT.
  - acertou=1 only in FIM_ACERTO.
  - errou=1 in FIM_ERRO and FIM_TIMEOUT.
  - timeout=1 only in FIM_TIMEOUT.
  - zeraC, zeraR, registraR and contaC are never asserted together; each is high only in its own state.
- Timeout counter tmo_cnt (TW bits):
  - Cleared to 0 in every state except ESPERA.
  - Increments each cycle spent in ESPERA.
  - Therefore ESPERA lasts at most TIMEOUT_CYCLES cycles per move, and the counter never wraps.
- Latency: jogada rising edge at cycle t -> registraR high in cycle t+1 -> result state reached by cycle t+3 (contaC in t+3 on a non-final match).
- Reset, asynchronous and valid at any time including mid-round:
  - state=INICIAL, jog_prev=0, tmo_cnt=0.
  - All outputs 0 and db_estado=0 while reset is high and immediately after release.
- iniciar held high across a round does not retrigger mid-round. It is sampled only in INICIAL and FIM_*.

Test Plan:
- Reset then idle: reset pulse, iniciar=0 for 10 cycles -> db_estado=0, all outputs 0; reset asserted mid-COMPARA -> db_estado=0 in the same cycle.
- Full correct round with a 4-address sequence: iniciar, then 4 jogada presses, each with chavesIgualMemoria=1 and fimC=1 on the 4th -> exactly 3 contaC pulses, 4 registraR pulses, final db_estado=A, pronto=1, acertou=1, errou=0.
- Mismatch on the 2nd move: chavesIgualMemoria=0 at the 2nd COMPARA -> db_estado=E, errou=1, acertou=0, timeout=0, exactly 1 contaC pulse.
- Timeout with TIMEOUT_CYCLES=20: no jogada after PREPARA -> FIM_TIMEOUT exactly 20 cycles after entering ESPERA; pronto=1, errou=1, timeout=1, db_estado=D.
- Edge and priority: jogada held high for 50 cycles -> a single registraR pulse. jogada rising in the last ESPERA cycle (tmo_cnt=19) -> REGISTRA, not timeout.
- Restart from an end state: in FIM_ERRO assert iniciar -> next state PREPARA with zeraC=zeraR=1 for one cycle, then ESPERA with the timeout counter restarted from 0.
